// File: rtl/regfile_port_decoder.sv
// regfile_port_decoder
//   Registered read/write wordline decoder plus a busy-bit scoreboard for the
//   register file. It sits between decode and the register-file bit array.
//
//   Parameters
//     ADDR_W   register ID width (NREGS = 2**ADDR_W, derived)
//     NUM_RD   number of read ports
//     ZERO_REG 1 = register 0 is hardwired zero (never written, never busy)
//
//   Ports
//     clk_i          clock, rising edge
//     rst_n_i        asynchronous active-low reset
//     rd_en_i        per-port read request
//     rd_addr_i      per-port register ID, port p at [p*ADDR_W +: ADDR_W]
//     wr_en_i        register-file write this cycle (retiring instruction)
//     wr_addr_i      write register ID
//     rsv_en_i       reserve destination register (issuing instruction)
//     rsv_addr_i     register ID to reserve
//     rd_wordline_o  registered one-hot read wordlines, port p at [p*NREGS +: NREGS]
//     rd_valid_o     registered; read requested and not stalled
//     rd_bypass_o    registered; port takes write data instead of array data
//     rd_stall_o     registered; port hit a busy register with no same-cycle write
//     wr_wordline_o  registered one-hot write wordline
//     busy_o         scoreboard, one bit per register
module regfile_port_decoder #(
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_RD-1:0]                 rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]          rd_addr_i,
  input  logic                              wr_en_i,
  input  logic [ADDR_W-1:0]                 wr_addr_i,
  input  logic                              rsv_en_i,
  input  logic [ADDR_W-1:0]                 rsv_addr_i,
  output logic [NUM_RD*(2**ADDR_W)-1:0]     rd_wordline_o,
  output logic [NUM_RD-1:0]                 rd_valid_o,
  output logic [NUM_RD-1:0]                 rd_bypass_o,
  output logic [NUM_RD-1:0]                 rd_stall_o,
  output logic [(2**ADDR_W)-1:0]            wr_wordline_o,
  output logic [(2**ADDR_W)-1:0]            busy_o
);

  localparam int NREGS = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [NUM_RD*NREGS-1:0] rd_wl_d, rd_wl_q;
  logic [NUM_RD-1:0]       rd_valid_d, rd_valid_q;
  logic [NUM_RD-1:0]       rd_bypass_d, rd_bypass_q;
  logic [NUM_RD-1:0]       rd_stall_d, rd_stall_q;
  logic [NREGS-1:0]        wr_wl_d, wr_wl_q;
  logic [NREGS-1:0]        busy_d, busy_q;

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Read ports: all conditions use the pre-edge scoreboard, so a reservation
  // made this cycle cannot stall a read made in the same cycle.
  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit_wr;
    logic              stall;
    rd_wl_d     = '0;
    rd_valid_d  = '0;
    rd_bypass_d = '0;
    rd_stall_d  = '0;
    addr        = '0;
    is_zero     = 1'b0;
    hit_wr      = 1'b0;
    stall       = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr    = rd_addr_i[p*ADDR_W +: ADDR_W];
      is_zero = ZR && (addr == '0);
      hit_wr  = wr_en_i && (wr_addr_i == addr);
      stall   = rd_en_i[p] && busy_q[addr] && !hit_wr && !is_zero;
      rd_bypass_d[p] = rd_en_i[p] && hit_wr && !is_zero;
      rd_stall_d[p]  = stall;
      rd_valid_d[p]  = rd_en_i[p] && !stall;
      if (rd_en_i[p] && !stall) begin
        rd_wl_d[p*NREGS +: NREGS] = onehot(addr);
      end
    end
  end

  always_comb begin
    wr_wl_d = '0;
    if (wr_en_i && !(ZR && (wr_addr_i == '0))) begin
      wr_wl_d = onehot(wr_addr_i);
    end
  end

  // Scoreboard: a same-cycle reservation wins over the retiring write because
  // it belongs to the younger instruction.
  always_comb begin
    logic set_r;
    logic clr_r;
    busy_d = '0;
    set_r  = 1'b0;
    clr_r  = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      set_r     = rsv_en_i && (rsv_addr_i == ADDR_W'(r));
      clr_r     = wr_en_i && (wr_addr_i == ADDR_W'(r));
      busy_d[r] = set_r || (busy_q[r] && !clr_r);
    end
    if (ZR) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_wl_q     <= '0;
      rd_valid_q  <= '0;
      rd_bypass_q <= '0;
      rd_stall_q  <= '0;
      wr_wl_q     <= '0;
      busy_q      <= '0;
    end else begin
      rd_wl_q     <= rd_wl_d;
      rd_valid_q  <= rd_valid_d;
      rd_bypass_q <= rd_bypass_d;
      rd_stall_q  <= rd_stall_d;
      wr_wl_q     <= wr_wl_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_wordline_o = rd_wl_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_bypass_o   = rd_bypass_q;
  assign rd_stall_o    = rd_stall_q;
  assign wr_wordline_o = wr_wl_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_regfile_port_decoder.sv
module tb_regfile_port_decoder;

  logic clk;
  logic rst_n;

  // default instance: ADDR_W=4, NUM_RD=2, ZERO_REG=1
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic [31:0] rd_wl;
  logic [1:0]  rd_valid, rd_byp, rd_stall;
  logic [15:0] wr_wl, busy;

  // wide instance: ADDR_W=5, NUM_RD=3, ZERO_REG=0
  logic [2:0]  rd_en5;
  logic [14:0] rd_addr5;
  logic        wr_en5;
  logic [4:0]  wr_addr5;
  logic        rsv_en5;
  logic [4:0]  rsv_addr5;
  logic [95:0] rd_wl5;
  logic [2:0]  rd_valid5, rd_byp5, rd_stall5;
  logic [31:0] wr_wl5, busy5;

  int checks = 0;
  int errors = 0;

  regfile_port_decoder #(.ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
    .rd_wordline_o(rd_wl), .rd_valid_o(rd_valid),
    .rd_bypass_o(rd_byp), .rd_stall_o(rd_stall),
    .wr_wordline_o(wr_wl), .busy_o(busy)
  );

  regfile_port_decoder #(.ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_en_i(rd_en5), .rd_addr_i(rd_addr5),
    .wr_en_i(wr_en5), .wr_addr_i(wr_addr5),
    .rsv_en_i(rsv_en5), .rsv_addr_i(rsv_addr5),
    .rd_wordline_o(rd_wl5), .rd_valid_o(rd_valid5),
    .rd_bypass_o(rd_byp5), .rd_stall_o(rd_stall5),
    .wr_wordline_o(wr_wl5), .busy_o(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;   // {port1, port0}
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [31:0] e_wl;
    logic [1:0]  e_valid;
    logic [1:0]  e_byp;
    logic [1:0]  e_stall;
    logic [15:0] e_wrwl;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; rsv_en = 1'b0; rsv_addr = '0;
    rd_en5 = '0; rd_addr5 = '0; wr_en5 = 1'b0; wr_addr5 = '0; rsv_en5 = 1'b0; rsv_addr5 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_wl"},    96'(rd_wl), 96'h0);
    check({tag, " rd_valid"}, 96'(rd_valid), 96'h0);
    check({tag, " rd_byp"},   96'(rd_byp), 96'h0);
    check({tag, " rd_stall"}, 96'(rd_stall), 96'h0);
    check({tag, " wr_wl"},    96'(wr_wl), 96'h0);
    check({tag, " busy"},     96'(busy), 96'h0);
    check({tag, " busy5"},    96'(busy5), 96'h0);
  endtask

  initial begin
    // rd_en rd_addr wr_en wr_addr rsv_en rsv_addr | wl valid byp stall wrwl busy
    vecs[0] = '{2'b00, 8'h00, 1'b0, 4'd0, 1'b1, 4'd5, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0020};
    vecs[1] = '{2'b01, 8'h05, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0000_0000, 2'b00, 2'b00, 2'b01, 16'h0000, 16'h0020};
    vecs[2] = '{2'b01, 8'h05, 1'b1, 4'd5, 1'b0, 4'd0, 32'h0000_0020, 2'b01, 2'b01, 2'b00, 16'h0020, 16'h0000};
    vecs[3] = '{2'b00, 8'h00, 1'b0, 4'd0, 1'b1, 4'd9, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0200};
    vecs[4] = '{2'b00, 8'h00, 1'b1, 4'd9, 1'b1, 4'd9, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 16'h0200, 16'h0200};
    vecs[5] = '{2'b00, 8'h00, 1'b0, 4'd0, 1'b1, 4'd0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0200};
    vecs[6] = '{2'b10, 8'h00, 1'b1, 4'd0, 1'b0, 4'd0, 32'h0001_0000, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0200};
    vecs[7] = '{2'b11, 8'h99, 1'b0, 4'd0, 1'b1, 4'd3, 32'h0000_0000, 2'b00, 2'b00, 2'b11, 16'h0000, 16'h0208};
    vecs[8] = '{2'b11, 8'h93, 1'b1, 4'd9, 1'b0, 4'd0, 32'h0200_0000, 2'b10, 2'b10, 2'b01, 16'h0200, 16'h0008};
    vecs[9] = '{2'b01, 8'h07, 1'b0, 4'd0, 1'b1, 4'd7, 32'h0000_0080, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0088};

    idle();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
      rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      tick();
      check($sformatf("vec%0d rd_wl", i),    96'(rd_wl),    96'(vecs[i].e_wl));
      check($sformatf("vec%0d rd_valid", i), 96'(rd_valid), 96'(vecs[i].e_valid));
      check($sformatf("vec%0d rd_byp", i),   96'(rd_byp),   96'(vecs[i].e_byp));
      check($sformatf("vec%0d rd_stall", i), 96'(rd_stall), 96'(vecs[i].e_stall));
      check($sformatf("vec%0d wr_wl", i),    96'(wr_wl),    96'(vecs[i].e_wrwl));
      check($sformatf("vec%0d busy", i),     96'(busy),     96'(vecs[i].e_busy));
    end
    idle();
    tick();

    // asynchronous reset between edges
    rsv_en = 1'b1; rsv_addr = 4'd3;
    tick();
    rsv_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd2; rd_en = 2'b01; rd_addr = 8'h04;
    tick();
    check("pre_reset busy", 96'(busy), 96'h0088);
    check("pre_reset wr_wl", 96'(wr_wl), 96'h0004);
    check("pre_reset rd_wl", 96'(rd_wl), 96'h0010);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    rsv_en = 1'b1; rsv_addr = 4'd3;
    tick();
    check("reset_hold busy", 96'(busy), 96'h0);
    #2 rst_n = 1'b1;
    idle();

    // exhaustive decode sweep
    for (int id = 0; id < 16; id++) begin
      logic [3:0]  a0, a1;
      logic [31:0] ewl;
      a0 = 4'(id);
      a1 = 4'(15 - id);
      rd_en = 2'b11; rd_addr = {a1, a0};
      ewl = (32'd1 << id) | (32'd1 << (16 + 15 - id));
      tick();
      check($sformatf("sweep%0d rd_wl", id),    96'(rd_wl),    96'(ewl));
      check($sformatf("sweep%0d rd_valid", id), 96'(rd_valid), 96'h3);
      check($sformatf("sweep%0d rd_stall", id), 96'(rd_stall), 96'h0);
    end
    idle();

    // wide instance: three ports, no hardwired zero
    rsv_en5 = 1'b1; rsv_addr5 = 5'd31;
    tick();
    check("w5 busy31", 96'(busy5), 96'h8000_0000);
    rsv_en5 = 1'b0;
    rd_en5 = 3'b111; rd_addr5 = {5'd31, 5'd0, 5'd31};
    tick();
    check("w5 rd_stall", 96'(rd_stall5), 96'h5);
    check("w5 rd_valid", 96'(rd_valid5), 96'h2);
    check("w5 rd_wl",    rd_wl5, {32'h0, 32'h0000_0001, 32'h0});
    rd_en5 = '0; rd_addr5 = '0;
    wr_en5 = 1'b1; wr_addr5 = 5'd0; rsv_en5 = 1'b1; rsv_addr5 = 5'd0;
    tick();
    check("w5 wr_wl0", 96'(wr_wl5), 96'h1);
    check("w5 busy0",  96'(busy5),  96'h8000_0001);
    wr_en5 = 1'b0; rsv_en5 = 1'b0;
    rd_en5 = 3'b010; rd_addr5 = {5'd0, 5'd0, 5'd0};
    tick();
    check("w5 r0 stall", 96'(rd_stall5), 96'h2);
    check("w5 r0 wl",    rd_wl5, 96'h0);
    idle();
    tick();

    // randomized run against a reference scoreboard
    begin
      bit          mb[16];
      logic [31:0] ewl;
      logic [1:0]  ev, eb, es;
      logic [15:0] ewr, ebusy;
      logic [3:0]  a;
      bit          hit;
      for (int r = 0; r < 16; r++) mb[r] = (busy[r] === 1'b1);
      for (int n = 0; n < 400; n++) begin
        rd_en    = 2'($urandom_range(0, 3));
        rd_addr  = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
        wr_en    = 1'($urandom_range(0, 1));
        wr_addr  = 4'($urandom_range(0, 7));
        rsv_en   = 1'($urandom_range(0, 1));
        rsv_addr = 4'($urandom_range(0, 7));
        ewl = '0; ev = '0; eb = '0; es = '0;
        for (int p = 0; p < 2; p++) begin
          a   = rd_addr[p*4 +: 4];
          hit = wr_en && (wr_addr == a);
          if (rd_en[p] && a != 0) begin
            eb[p] = hit;
            es[p] = mb[a] && !hit;
          end
          ev[p] = rd_en[p] && !es[p];
          if (ev[p]) ewl = ewl | (32'd1 << (p * 16 + int'(a)));
        end
        ewr = (wr_en && wr_addr != 0) ? (16'd1 << wr_addr) : 16'd0;
        if (wr_en && wr_addr != 0) mb[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != 0) mb[rsv_addr] = 1'b1;
        ebusy = '0;
        for (int r = 0; r < 16; r++) ebusy[r] = mb[r];
        tick();
        check($sformatf("rnd%0d rd_wl", n),    96'(rd_wl),    96'(ewl));
        check($sformatf("rnd%0d rd_valid", n), 96'(rd_valid), 96'(ev));
        check($sformatf("rnd%0d rd_byp", n),   96'(rd_byp),   96'(eb));
        check($sformatf("rnd%0d rd_stall", n), 96'(rd_stall), 96'(es));
        check($sformatf("rnd%0d wr_wl", n),    96'(wr_wl),    96'(ewr));
        check($sformatf("rnd%0d busy", n),     96'(busy),     96'(ebusy));
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
